// File: rtl/ucode_sequencer_if.sv
// Handshake bundle between the opcode source, the sequencer and the microcode unit.
interface ucode_sequencer_if #(
  parameter int OPW = 6
);
  logic           instr_valid;
  logic [OPW-1:0] instr_opcode;
  logic           instr_ready;
  logic [OPW-1:0] uc_opcode;
  logic           uc_sos;
  logic           uc_eos;

  // Environment side: opcode source plus the microcode unit's eos return.
  modport master (
    output instr_valid, instr_opcode, uc_eos,
    input  instr_ready, uc_opcode, uc_sos
  );

  // Sequencer side.
  modport slave (
    input  instr_valid, instr_opcode, uc_eos,
    output instr_ready, uc_opcode, uc_sos
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Dispatch controller in front of the microcode unit: accepts one opcode at a
// time, launches its segment with a one-cycle sos pulse, waits for eos and
// retires it. Halt and illegal opcodes and hung segments park the FSM in a
// sticky state until reset.
module ucode_sequencer #(
  parameter int             OPW       = 6,
  parameter logic [OPW-1:0] HALT_OP   = 6'h3F,
  parameter int             SEG_COUNT = 2,
  parameter int             TIMEOUT   = 64,
  parameter int             CNTW      = 16
) (
  input  logic                clk,
  input  logic                rst,
  ucode_sequencer_if.slave    bus,
  output logic                busy,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [CNTW-1:0]     retired_count
);

  localparam int             TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [OPW:0]   SEG_LIM    = (OPW + 1)'(SEG_COUNT);

  typedef enum logic [2:0] {IDLE, LAUNCH, EXEC, HALT, FAULT} state_t;

  state_t          state, state_next;
  logic            ready_q;
  logic            sos_q;
  logic [OPW-1:0]  opcode_q;
  logic [TW-1:0]   timer;
  logic            do_halt, do_illegal, do_launch, do_retire, do_timeout;

  // State register; rst wins from every state, including HALT and FAULT.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode. Timer value 0 marks the settle cycle where eos is ignored;
  // eos is tested before the timeout so it wins on the final cycle.
  always_comb begin
    state_next = state;
    do_halt    = 1'b0;
    do_illegal = 1'b0;
    do_launch  = 1'b0;
    do_retire  = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (bus.instr_valid && ready_q) begin
          if (bus.instr_opcode == HALT_OP) begin
            do_halt    = 1'b1;
            state_next = HALT;
          end else if ({1'b0, bus.instr_opcode} >= SEG_LIM) begin
            do_illegal = 1'b1;
            state_next = FAULT;
          end else begin
            do_launch  = 1'b1;
            state_next = LAUNCH;
          end
        end
      end
      LAUNCH: state_next = EXEC;
      EXEC: begin
        if (bus.uc_eos && (timer != '0)) begin
          do_retire  = 1'b1;
          state_next = IDLE;
        end else if (timer == TIMER_LAST) begin
          do_timeout = 1'b1;
          state_next = FAULT;
        end
      end
      HALT:    state_next = HALT;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, opcode latch, fault code, wait timer and retire counter.
  // ready/sos are derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q       <= 1'b0;
      sos_q         <= 1'b0;
      opcode_q      <= '0;
      fault_code    <= 2'b00;
      timer         <= '0;
      retired_count <= '0;
    end else begin
      ready_q <= (state_next == IDLE);
      sos_q   <= (state_next == LAUNCH);
      if (do_halt)        opcode_q <= HALT_OP;
      else if (do_launch) opcode_q <= bus.instr_opcode;
      if (do_illegal)      fault_code <= 2'b01;
      else if (do_timeout) fault_code <= 2'b10;
      if (state == LAUNCH)    timer <= '0;
      else if (state == EXEC) timer <= timer + 1'b1;
      if (do_retire && (retired_count != '1)) retired_count <= retired_count + 1'b1;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.uc_sos      = sos_q;
  assign bus.uc_opcode   = opcode_q;
  assign busy            = (state == LAUNCH) || (state == EXEC);
  assign halted          = (state == HALT);
  assign fault           = (state == FAULT);

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: reset, retire timing, eos settle cycle,
// halt, illegal opcode, eos timeout, reset mid-segment and back-to-back ops.
module tb_ucode_sequencer;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, halted, fault;
  logic [1:0]  fault_code;
  logic [15:0] retired_count;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          sos_cnt = 0;
  int          sos_dbl = 0;
  logic        prev_sos = 1'b0;
  int          base;

  ucode_sequencer_if #(.OPW(6)) bus ();

  ucode_sequencer #(.OPW(6), .HALT_OP(6'h3F), .SEG_COUNT(2), .TIMEOUT(TIMEOUT), .CNTW(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault),
    .fault_code    (fault_code),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  // Count sos pulses and any back-to-back sos cycles.
  always @(posedge clk) begin
    if (bus.uc_sos === 1'b1) begin
      sos_cnt <= sos_cnt + 1;
      if (prev_sos) sos_dbl <= sos_dbl + 1;
    end
    prev_sos <= (bus.uc_sos === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_opcode = '0;
    bus.uc_eos = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Best-case op: transfer, LAUNCH, settle, eos seen on the 2nd EXEC cycle.
  task automatic run_op(input logic [5:0] op);
    bus.instr_valid = 1'b1;
    bus.instr_opcode = op;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    bus.uc_eos = 1'b1;
    tick();
    tick();
    bus.uc_eos = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_opcode = 6'd0;
    bus.uc_eos = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.instr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus.instr_ready); end
    n_cmp++; if (bus.uc_opcode !== 6'h00) begin n_bad++; $display("FAIL rst_opcode: got %h want 00", bus.uc_opcode); end
    n_cmp++; if (bus.uc_sos !== 1'b0) begin n_bad++; $display("FAIL rst_sos: got %b want 0", bus.uc_sos); end
    n_cmp++; if ({busy, halted, fault} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {busy, halted, fault}); end
    n_cmp++; if (fault_code !== 2'b00) begin n_bad++; $display("FAIL rst_fcode: got %b want 00", fault_code); end
    n_cmp++; if (retired_count !== 16'd0) begin n_bad++; $display("FAIL rst_retired: got %0d want 0", retired_count); end
    bus.instr_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_rise: got %b want 1", bus.instr_ready); end
  endtask

  task automatic test_op0_late_eos();
    do_reset();
    base = sos_cnt;
    bus.instr_valid = 1'b1;
    bus.instr_opcode = 6'd0;
    tick();
    bus.instr_valid = 1'b0;
    n_cmp++; if ({bus.uc_sos, bus.instr_ready, busy} !== 3'b101) begin n_bad++; $display("FAIL op0_launch: got sos/ready/busy %b want 101", {bus.uc_sos, bus.instr_ready, busy}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({bus.uc_sos, busy, bus.uc_opcode} !== {2'b01, 6'h00}) begin n_bad++; $display("FAIL op0_exec%0d: got sos/busy/op %b %b %h want 0 1 00", i, bus.uc_sos, busy, bus.uc_opcode); end
    end
    n_cmp++; if (retired_count !== 16'd0) begin n_bad++; $display("FAIL op0_early_retire: got %0d want 0", retired_count); end
    bus.uc_eos = 1'b1;
    tick();
    bus.uc_eos = 1'b0;
    n_cmp++; if (retired_count !== 16'd1) begin n_bad++; $display("FAIL op0_retired: got %0d want 1", retired_count); end
    n_cmp++; if ({bus.instr_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL op0_ready_back: got ready/busy %b want 10", {bus.instr_ready, busy}); end
    n_cmp++; if (sos_cnt - base !== 1) begin n_bad++; $display("FAIL op0_sos_pulses: got %0d want 1", sos_cnt - base); end
  endtask

  task automatic test_eos_settle();
    do_reset();
    bus.instr_valid = 1'b1;
    bus.instr_opcode = 6'd1;
    tick();
    bus.instr_valid = 1'b0;
    bus.uc_eos = 1'b1;
    tick();
    n_cmp++; if ({busy, retired_count} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL settle_exec1: got busy %b retired %0d want 1 0", busy, retired_count); end
    tick();
    n_cmp++; if ({busy, retired_count} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL settle_ignored: got busy %b retired %0d want 1 0", busy, retired_count); end
    n_cmp++; if (bus.uc_opcode !== 6'h01) begin n_bad++; $display("FAIL settle_opcode: got %h want 01", bus.uc_opcode); end
    tick();
    bus.uc_eos = 1'b0;
    n_cmp++; if ({busy, bus.instr_ready, retired_count} !== {2'b01, 16'd1}) begin n_bad++; $display("FAIL settle_retire: got busy %b ready %b retired %0d want 0 1 1", busy, bus.instr_ready, retired_count); end
  endtask

  task automatic test_halt();
    do_reset();
    base = sos_cnt;
    bus.instr_valid = 1'b1;
    bus.instr_opcode = 6'h3F;
    tick();
    n_cmp++; if ({halted, fault, busy, bus.instr_ready} !== 4'b1000) begin n_bad++; $display("FAIL halt_flags: got %b want 1000", {halted, fault, busy, bus.instr_ready}); end
    n_cmp++; if (bus.uc_opcode !== 6'h3F) begin n_bad++; $display("FAIL halt_opcode: got %h want 3f", bus.uc_opcode); end
    bus.instr_opcode = 6'd0;
    tick();
    tick();
    tick();
    bus.instr_valid = 1'b0;
    n_cmp++; if ({halted, bus.uc_opcode} !== {1'b1, 6'h3F}) begin n_bad++; $display("FAIL halt_sticky: got halted %b op %h want 1 3f", halted, bus.uc_opcode); end
    n_cmp++; if (sos_cnt - base !== 0) begin n_bad++; $display("FAIL halt_sos: got %0d want 0", sos_cnt - base); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({halted, bus.uc_opcode} !== {1'b0, 6'h00}) begin n_bad++; $display("FAIL halt_rst: got halted %b op %h want 0 00", halted, bus.uc_opcode); end
  endtask

  task automatic test_illegal();
    do_reset();
    base = sos_cnt;
    bus.instr_valid = 1'b1;
    bus.instr_opcode = 6'd5;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    n_cmp++; if ({fault, fault_code, bus.instr_ready, busy} !== 5'b10100) begin n_bad++; $display("FAIL illegal_flags: got %b want 10100", {fault, fault_code, bus.instr_ready, busy}); end
    n_cmp++; if (bus.uc_opcode !== 6'h00) begin n_bad++; $display("FAIL illegal_opcode: got %h want 00", bus.uc_opcode); end
    n_cmp++; if (sos_cnt - base !== 0) begin n_bad++; $display("FAIL illegal_sos: got %0d want 0", sos_cnt - base); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.instr_valid = 1'b1;
    bus.instr_opcode = 6'd0;
    tick();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) tick();
    n_cmp++; if ({busy, fault} !== 2'b10) begin n_bad++; $display("FAIL tmo_last_exec: got busy/fault %b want 10", {busy, fault}); end
    tick();
    n_cmp++; if ({fault, fault_code, busy} !== 4'b1100) begin n_bad++; $display("FAIL tmo_fault: got %b want 1100", {fault, fault_code, busy}); end
    do_reset();
    bus.instr_valid = 1'b1;
    bus.instr_opcode = 6'd0;
    tick();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) tick();
    bus.uc_eos = 1'b1;
    tick();
    bus.uc_eos = 1'b0;
    n_cmp++; if ({fault, fault_code, retired_count, bus.instr_ready} !== {3'b000, 16'd1, 1'b1}) begin n_bad++; $display("FAIL tmo_eos_wins: got fault %b code %b retired %0d ready %b want 0 00 1 1", fault, fault_code, retired_count, bus.instr_ready); end
  endtask

  task automatic test_rst_mid_exec();
    do_reset();
    run_op(6'd0);
    bus.instr_valid = 1'b1;
    bus.instr_opcode = 6'd1;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if ({busy, retired_count} !== {1'b1, 16'd1}) begin n_bad++; $display("FAIL mid_pre: got busy %b retired %0d want 1 1", busy, retired_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({busy, halted, fault, fault_code, bus.uc_sos, bus.instr_ready} !== 7'b0000000) begin n_bad++; $display("FAIL mid_rst_flags: got %b want 0000000", {busy, halted, fault, fault_code, bus.uc_sos, bus.instr_ready}); end
    n_cmp++; if ({bus.uc_opcode, retired_count} !== {6'h00, 16'd0}) begin n_bad++; $display("FAIL mid_rst_regs: got op %h retired %0d want 00 0", bus.uc_opcode, retired_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    base = sos_cnt;
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready0: got %b want 1", bus.instr_ready); end
    run_op(6'd0);
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready1: got %b want 1", bus.instr_ready); end
    run_op(6'd1);
    n_cmp++; if (bus.uc_opcode !== 6'h01) begin n_bad++; $display("FAIL b2b_opcode: got %h want 01", bus.uc_opcode); end
    run_op(6'd0);
    n_cmp++; if (retired_count !== 16'd3) begin n_bad++; $display("FAIL b2b_retired: got %0d want 3", retired_count); end
    n_cmp++; if (sos_cnt - base !== 3) begin n_bad++; $display("FAIL b2b_sos: got %0d want 3", sos_cnt - base); end
    n_cmp++; if (sos_dbl !== 0) begin n_bad++; $display("FAIL sos_consecutive: got %0d want 0", sos_dbl); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_op0_late_eos();
    test_eos_settle();
    test_halt();
    test_illegal();
    test_timeout();
    test_rst_mid_exec();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
